// File: rtl/instruction_cache.sv
// Direct-mapped 4-line x 4-word instruction cache with a single outstanding
// block fill from instruction_mem and a 16-bit miss counter.
module instruction_cache (
  input  logic         clock,
  input  logic         reset,
  input  logic         req,
  input  logic [31:0]  pc,
  input  logic         flush,
  output logic [31:0]  instruction,
  output logic         hit,
  output logic         stall,
  output logic         mem_enable,
  output logic [31:0]  mem_address,
  input  logic [127:0] mem_data,
  input  logic         mem_valid,
  output logic [15:0]  miss_count
);

  localparam int unsigned LINES   = 4;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned TAG_W   = 28;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {READY, FETCH, RELEASE} state_e;

  state_e             state_q, state_d;
  logic               mem_enable_q, mem_enable_d;
  logic [31:0]        mem_address_q, mem_address_d;
  logic [CNT_W-1:0]   miss_count_q, miss_count_d;
  logic [LINES-1:0]   line_valid_q, line_valid_d;
  logic               fill_kill_q, fill_kill_d;
  logic               fill_we;

  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  logic [1:0]         idx;
  logic [1:0]         fill_idx;
  logic               lookup_hit;

  // The latched block address doubles as the miss pc for the fill.
  assign idx        = pc[3:2];
  assign fill_idx   = mem_address_q[3:2];
  assign lookup_hit = line_valid_q[idx] && (tag_q[idx] == pc[31:4]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= READY;
      mem_enable_q  <= 1'b0;
      mem_address_q <= '0;
      miss_count_q  <= '0;
      line_valid_q  <= '0;
      fill_kill_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_enable_q  <= mem_enable_d;
      mem_address_q <= mem_address_d;
      miss_count_q  <= miss_count_d;
      line_valid_q  <= line_valid_d;
      fill_kill_q   <= fill_kill_d;
    end
  end

  // Tag/data arrays need no reset; line_valid qualifies them.
  always_ff @(posedge clock) begin
    if (fill_we) begin
      data_q[fill_idx] <= mem_data;
      tag_q[fill_idx]  <= mem_address_q[31:4];
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_enable_d  = mem_enable_q;
    mem_address_d = mem_address_q;
    miss_count_d  = miss_count_q;
    line_valid_d  = line_valid_q;
    fill_kill_d   = fill_kill_q;
    fill_we       = 1'b0;
    hit           = 1'b0;

    unique case (state_q)
      READY: begin
        hit = req && lookup_hit && !flush;
        if (req && !lookup_hit && !flush) begin
          mem_enable_d  = 1'b1;
          mem_address_d = {pc[31:2], 2'b00};
          miss_count_d  = miss_count_q + CNT_W'(1);
          state_d       = FETCH;
        end
      end
      FETCH: begin
        if (flush) fill_kill_d = 1'b1;
        if (mem_valid) begin
          fill_we = 1'b1;
          if (!fill_kill_q && !flush) line_valid_d[fill_idx] = 1'b1;
          mem_enable_d = 1'b0;
          fill_kill_d  = 1'b0;
          state_d      = RELEASE;
        end
      end
      RELEASE: begin
        state_d = READY;
      end
      default: begin
        state_d = READY;
      end
    endcase

    if (flush) line_valid_d = '0;
  end

  assign stall       = req && !hit;
  assign instruction = data_q[idx][{pc[1:0], 5'b00000} +: WORD_W];
  assign mem_enable  = mem_enable_q;
  assign mem_address = mem_address_q;
  assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized self-checking bench for instruction_cache with a latency-programmable
// memory responder and a line-level reference model.
module tb_instruction_cache;

  logic         clock;
  logic         reset;
  logic         req;
  logic [31:0]  pc;
  logic         flush;
  logic [31:0]  instruction;
  logic         hit;
  logic         stall;
  logic         mem_enable;
  logic [31:0]  mem_address;
  logic [127:0] mem_data;
  logic         mem_valid;
  logic [15:0]  miss_count;

  instruction_cache dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .pc         (pc),
    .flush      (flush),
    .instruction(instruction),
    .hit        (hit),
    .stall      (stall),
    .mem_enable (mem_enable),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .miss_count (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: which block each line holds and how many misses occurred.
  bit          mv   [4];
  logic [27:0] mtag [4];
  int unsigned mcount = 0;

  int unsigned force_lat = 0;
  int unsigned last_lat  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] w);
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
  endtask

  // Memory responder: reacts only to rising edges of mem_enable, answers after L cycles.
  initial begin
    logic        en_prev;
    int unsigned cnt;
    logic [31:0] blk;
    en_prev   = 1'b0;
    cnt       = 0;
    blk       = '0;
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(posedge clock); #1;
      mem_valid = 1'b0;
      if (mem_enable && !en_prev) begin
        last_lat = (force_lat != 0) ? force_lat : $urandom_range(12, 4);
        cnt      = last_lat;
        blk      = mem_address;
      end
      en_prev = mem_enable;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_valid = 1'b1;
          for (int k = 0; k < 4; k++) mem_data[32*k +: 32] = mem_word(blk + 32'(k));
        end
      end
    end
  end

  task automatic idle();
    req = 1'b0; flush = 1'b0;
    @(negedge clock);
    check("idle_hit", 32'(hit), 32'd0);
    check("idle_stall", 32'(stall), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    logic [1:0] i;
    bit         exp_hit;
    bit         h;
    logic       prev_en;
    int         cyc;
    i = a[3:2];
    req = 1'b1; pc = a; flush = 1'b0;
    exp_hit = mv[i] && (mtag[i] == a[31:4]);
    @(negedge clock);
    check("first_hit", 32'(hit), 32'(exp_hit));
    check("first_stall", 32'(stall), 32'(!exp_hit));
    if (exp_hit) begin
      check("hit_instr", instruction, mem_word(a));
      check("hit_en_idle", 32'(mem_enable), 32'd0);
    end else begin
      cyc = 0; h = 1'b0; prev_en = mem_enable;
      while (!h && cyc < 60) begin
        prev_en = mem_enable;
        @(negedge clock);
        cyc++;
        h = hit;
        if (cyc == 1) begin
          check("miss_en_rise", 32'(mem_enable), 32'd1);
          check("miss_addr", mem_address, {a[31:2], 2'b00});
        end
        if (!h) pc = (cyc < int'(last_lat)) ? $urandom : a;
      end
      check("miss_served", 32'(h), 32'd1);
      check("miss_penalty", 32'(cyc), last_lat + 32'd2);
      check("release_low", 32'(prev_en), 32'd0);
      check("miss_instr", instruction, mem_word(a));
      mv[i] = 1'b1; mtag[i] = a[31:4]; mcount++;
      check("miss_count", 32'(miss_count), 32'(16'(mcount)));
    end
    @(posedge clock); #1;
  endtask

  task automatic flush_ready(input logic [31:0] a);
    req = 1'b1; pc = a; flush = 1'b1;
    @(negedge clock);
    check("flush_hit", 32'(hit), 32'd0);
    check("flush_stall", 32'(stall), 32'd1);
    @(posedge clock); #1;
    req = 1'b0; flush = 1'b0;
    model_clear();
    @(negedge clock);
    check("flush_no_req", 32'(mem_enable), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic flush_fetch(input logic [31:0] a);
    int n;
    req = 1'b1; pc = a; flush = 1'b0;
    @(negedge clock);
    check("ff_stall", 32'(stall), 32'd1);
    mcount++;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if (c == 1) check("ff_en", 32'(mem_enable), 32'd1);
      if (c == 3) flush = 1'b1;
    end
    @(negedge clock);
    flush = 1'b0; req = 1'b0;
    model_clear();
    n = 0;
    while (mem_enable && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("ff_en_drop", 32'(mem_enable), 32'd0);
    check("ff_count", 32'(miss_count), 32'(16'(mcount)));
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    model_clear();
    reset = 1'b1; req = 1'b1; pc = 32'h5; flush = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_en", 32'(mem_enable), 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_count", 32'(miss_count), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // First fetch, same-line hits, conflict eviction.
    force_lat = 11;
    do_fetch(32'h5);
    do_fetch(32'h4); do_fetch(32'h6); do_fetch(32'h7);
    force_lat = 0;
    do_fetch(32'h4); do_fetch(32'h14); do_fetch(32'h4);
    check("evict_count", 32'(miss_count), 32'd3);

    // Back-to-back misses.
    do_fetch(32'h0); do_fetch(32'h8);

    // Flush in READY and during FETCH.
    flush_ready(32'h0C);
    flush_fetch(32'h0C);
    idle();
    do_fetch(32'h0C);

    // Reset mid-FETCH with a stale response arriving later.
    req = 1'b1; pc = 32'h20;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("midrst_en", 32'(mem_enable), 32'd0);
    check("midrst_count", 32'(miss_count), 32'd0);
    check("midrst_stall", 32'(stall), 32'd1);
    req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear(); mcount = 0;
    repeat (20) idle();
    check("stale_count", 32'(miss_count), 32'd0);
    do_fetch(32'h20); do_fetch(32'h4);

    // Randomized traffic with conflicts, flushes and idle cycles.
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      a = (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
      if (r == 9) a = a | 32'hF000_0000;
      if (r == 0) idle();
      else if (r == 1) flush_ready(a);
      else do_fetch(a);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

- Direct-mapped, 4-line instruction cache between the fetch stage and `instruction_mem`.
- Serves 32-bit instruction reads from cached 128-bit blocks.
- On a miss, drives the memory's rising-edge-triggered read request and holds it until `mem_valid`, then fills the line.
- Counts misses for performance monitoring.

## Interface
Parameters: none. Geometry is fixed at 4 lines × 4 words; addresses are word addresses.

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  1  fetch stage requests the instruction at `pc`
- `pc`  in  32  word address; offset `pc[1:0]`, index `pc[3:2]`, tag `pc[31:4]`
- `flush`  in  1  invalidate all lines (single-cycle pulse or level)
- `instruction`  out  32  selected word of the indexed line; meaningful only when `hit`
- `hit`  out  1  `req` is served this cycle
- `stall`  out  1  `req && !hit`
- `mem_enable`  out  1  read request to `instruction_mem`; memory acts on its rising edge
- `mem_address`  out  32  block-aligned address: `{miss_pc[31:2], 2'b00}`
- `mem_data`  in  128  block from memory; word k is at bits `[32k+31:32k]`
- `mem_valid`  in  1  one-cycle pulse; `mem_data` is valid in that cycle
- `miss_count`  out  16  number of misses accepted since reset; wraps at 0xFFFF→0

## Operation
Storage, per line: `line_valid` (1 bit), `tag` (28 bits), `data` (128 bits).

States: READY, FETCH, RELEASE.

**READY**
- `hit = req && line_valid[idx] && tag[idx] == pc[31:4] && !flush`.
- `instruction = data[idx][32*pc[1:0] +: 32]`, combinational.
- On `req && !hit && !flush`:
  - latch `miss_pc <= pc`;
  - `mem_enable <= 1`;
  - `mem_address <= {pc[31:2], 2'b00}`;
  - `miss_count <= miss_count + 1`;
  - go to FETCH.
- `mem_valid` is ignored in READY.

**FETCH**
- Hold `mem_enable = 1` and `mem_address` stable; `hit = 0`.
- On `mem_valid`:
  - write `mem_data` into line `miss_pc[3:2]` and set its `tag = miss_pc[31:4]`;
  - set `line_valid` only if no flush was seen during this FETCH (including the current cycle);
  - `mem_enable <= 0`;
  - go to RELEASE.
- Waits indefinitely; there is no timeout.

**RELEASE**
- `mem_enable` stays 0, which guarantees a low cycle so the next request produces a new rising edge.
- `hit = 0`.
- Go to READY unconditionally.

**Flush**
- Clears every `line_valid` at the clock edge in any state.
- A flush in FETCH sets a `fill_kill` flag, cleared on leaving FETCH. The in-flight fill still completes the handshake but leaves the line invalid.

**Other rules**
- `pc` changing during FETCH has no effect on the memory side; the latched `miss_pc` governs.
- Reset mid-FETCH: everything returns to reset values immediately. Any later `mem_valid` pulse arrives in READY and is ignored.

## Timing
- Reset values:
  - state READY;
  - `mem_enable = 0`, `mem_address = 0`, `miss_count = 0`;
  - all `line_valid = 0`, `fill_kill = 0`;
  - `hit = 0` and `stall = req`.
- Hit latency: 0 cycles (combinational, same cycle as `req`).
- `mem_enable` rises 1 edge after the miss cycle.
- Fill is written at the edge that samples `mem_valid`. RELEASE lasts 1 cycle, and the refetch then hits in the following READY cycle.
- Miss penalty: memory latency L + 2 cycles. L is the number of cycles from `mem_enable` rising to `mem_valid`; it is ≈11 with the current memory model.
- `mem_enable` high-time equals L; low-time between requests is ≥ 1 cycle (RELEASE), plus ≥ 1 cycle in READY.

## Test plan
1. **Reset, then first fetch.**
   - `req=1, pc=0x00000005` → `stall=1`.
   - `mem_enable` rises next cycle with `mem_address=0x00000004`.
   - Memory returns `mem_data={W7,W6,W5,W4}` after 11 cycles → `hit=1, instruction=W5` in the cycle after RELEASE; `miss_count=1`.
2. **Same-line hits.** After test 1, `pc=0x4, 0x6, 0x7` on consecutive cycles → `hit=1` with W4, W6, W7 and no `mem_enable` activity; `miss_count` stays 1.
3. **Conflict eviction.** Fill `pc=0x04`, then `pc=0x14` (same index 1, different tag) → miss and refill. Then `pc=0x04` misses again; `miss_count=3`.
4. **Back-to-back misses.** `pc=0x00` then `pc=0x08`; the memory model raises `mem_valid` only on detected rising edges → `mem_enable` is low for ≥ 1 cycle between the two requests and both fills complete.
5. **Flush during FETCH.** Pulse `flush` 3 cycles into FETCH for `pc=0x0C` → the fill completes and `mem_enable` drops. The next `req pc=0x0C` misses again and issues a new request.
6. **Reset mid-FETCH.** Assert `reset` during FETCH, release it, and let a stale `mem_valid` arrive → it is ignored: `line_valid` remains all 0, `mem_enable=0`, `miss_count=0`.
